// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types and the hazard unit FSM state encoding
// regbits_t: register-file index; hazard_state_t: hazard unit FSM state
package cpu_types_pkg;
    typedef logic [4:0] regbits_t;
    typedef logic [1:0] hazard_state_t;
    localparam hazard_state_t RUN      = 2'd0;
    localparam hazard_state_t LU_STALL = 2'd1;
    localparam hazard_state_t DWAIT    = 2'd2;
    localparam hazard_state_t HALTED   = 2'd3;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline status in, stage enables/flushes/counters out
// inputs : ifid_rs, ifid_rt, idex_MemRead, idex_rt, exmem_dmemreq, dhit, ihit, exmem_pcsrc, memwb_halt
// outputs: pc/ifid/idex/exmem/memwb enables, ifid/idex/exmem flushes, halt_out, stall_cnt, flush_cnt
interface hazard_unit_if import cpu_types_pkg::*; #(parameter int CNT_W = 16);
    regbits_t ifid_rs, ifid_rt, idex_rt;
    logic idex_MemRead, exmem_dmemreq, dhit, ihit, exmem_pcsrc, memwb_halt;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, halt_out;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport hu (
        input  ifid_rs, ifid_rt, idex_MemRead, idex_rt, exmem_dmemreq, dhit, ihit, exmem_pcsrc, memwb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
               halt_out, stall_cnt, flush_cnt
    );
    modport slave (
        input  ifid_rs, ifid_rt, idex_MemRead, idex_rt, exmem_dmemreq, dhit, ihit, exmem_pcsrc, memwb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
               halt_out, stall_cnt, flush_cnt
    );
    modport master (
        output ifid_rs, ifid_rt, idex_MemRead, idex_rt, exmem_dmemreq, dhit, ihit, exmem_pcsrc, memwb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
               halt_out, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones
// CLK/RST: clock, async active-high reset; inc: count this cycle; cnt: current count
module sat_counter #(parameter int W = 16) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge CLK or posedge RST)
        if (RST) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control FSM with stall and flush performance counters
// CLK/RST: clock, async active-high reset; bus: hazard_unit_if.hu (pipeline status in, control out)
module hazard_unit import cpu_types_pkg::*; #(parameter int CNT_W = 16) (
    input logic      CLK,
    input logic      RST,
    hazard_unit_if.hu bus
);
    hazard_state_t state, nextState;
    logic loadUse, dataPend, pcFlush, stallInc;
    logic [4:0] en;
    logic [2:0] fl;
    // a load into r0 never creates a real dependency
    assign loadUse = bus.idex_MemRead && bus.idex_rt != '0 &&
                     (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);
    assign dataPend = bus.exmem_dmemreq && !bus.dhit;
    // en = {pc, ifid, idex, exmem, memwb}, fl = {ifid, idex, exmem}
    always_comb begin
        nextState = state;
        en = '1;
        fl = '0;
        pcFlush = 1'b0;
        if (state == RUN) begin
            if (bus.memwb_halt) begin
                nextState = HALTED;
                en = '0;
            end else if (dataPend) begin
                nextState = DWAIT;
                en = '0;
            end else if (bus.exmem_pcsrc) begin
                pcFlush = 1'b1;
                fl = '1;
            end else if (loadUse) begin
                nextState = LU_STALL;
                en = 5'b00111;
                fl = 3'b010;
            end else if (!bus.ihit) begin
                en = 5'b01111;
                fl = 3'b100;
            end
        end else if (state == LU_STALL) begin
            nextState = RUN;
            pcFlush = bus.exmem_pcsrc;
            fl = {3{bus.exmem_pcsrc}};
        end else if (state == DWAIT) begin
            nextState = bus.dhit ? RUN : DWAIT;
            en = {5{bus.dhit}};
        end else begin
            en = '0;
        end
        // reset must present a free-running pipeline regardless of inputs
        if (RST) begin
            en = '1;
            fl = '0;
            pcFlush = 1'b0;
        end
    end
    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= RUN;
        else state <= nextState;
    assign stallInc = !en[4] && state != HALTED;
    assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en} = en;
    assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush} = fl;
    assign bus.halt_out = state == HALTED;
    sat_counter #(.W(CNT_W)) stallCounter (.CLK(CLK), .RST(RST), .inc(stallInc), .cnt(bus.stall_cnt));
    sat_counter #(.W(CNT_W)) flushCounter (.CLK(CLK), .RST(RST), .inc(pcFlush), .cnt(bus.flush_cnt));
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit with directed cases and random stimulus
module tb_hazard_unit;
    import cpu_types_pkg::*;
    localparam int CNT_W = 4;
    localparam int SAT = (1 << CNT_W) - 1;
    typedef struct packed {
        logic rst, memRead, dmemreq, dhit, ihit, pcsrc, halt;
        regbits_t rs, rt, exRt;
    } stim_t;
    typedef struct packed {
        logic [4:0] en;
        logic [2:0] fl;
        logic halt;
        logic [CNT_W-1:0] stall, flush;
    } resp_t;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    hazard_unit_if #(.CNT_W(CNT_W)) bus();
    hazard_unit #(.CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    resp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    bit halted, waiting, bubble;
    int stalls, flushes;
    function automatic logic [4:0] enables();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
    endfunction
    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ihit = 1'b1;
        s.dhit = 1'b1;
        return s;
    endfunction
    task automatic predict(input stim_t s, output resp_t r);
        bit lu, takeFlush;
        lu = s.memRead && s.exRt != 0 && (s.exRt == s.rs || s.exRt == s.rt);
        takeFlush = 1'b0;
        r.en = '1;
        r.fl = '0;
        r.halt = s.rst ? 1'b0 : halted;
        r.stall = s.rst ? '0 : CNT_W'(stalls);
        r.flush = s.rst ? '0 : CNT_W'(flushes);
        if (s.rst) begin
            halted = 0;
            waiting = 0;
            bubble = 0;
            stalls = 0;
            flushes = 0;
            return;
        end
        if (halted) r.en = '0;
        else if (waiting) begin
            r.en = s.dhit ? 5'h1f : 5'h00;
            waiting = !s.dhit;
        end else if (bubble) begin
            takeFlush = s.pcsrc;
            bubble = 0;
        end else if (s.halt) begin
            r.en = '0;
            halted = 1;
        end else if (s.dmemreq && !s.dhit) begin
            r.en = '0;
            waiting = 1;
        end else if (s.pcsrc) takeFlush = 1;
        else if (lu) begin
            r.en = 5'b00111;
            r.fl = 3'b010;
            bubble = 1;
        end else if (!s.ihit) begin
            r.en = 5'b01111;
            r.fl = 3'b100;
        end
        if (takeFlush) r.fl = 3'b111;
        if (!r.en[4] && !r.halt && stalls < SAT) stalls++;
        if (takeFlush && flushes < SAT) flushes++;
    endtask
    task automatic step(input stim_t s);
        resp_t r;
        @(posedge CLK);
        #1;
        RST = s.rst;
        bus.idex_MemRead = s.memRead;
        bus.exmem_dmemreq = s.dmemreq;
        bus.dhit = s.dhit;
        bus.ihit = s.ihit;
        bus.exmem_pcsrc = s.pcsrc;
        bus.memwb_halt = s.halt;
        bus.ifid_rs = s.rs;
        bus.ifid_rt = s.rt;
        bus.idex_rt = s.exRt;
        predict(s, r);
        sb.push_back(r);
    endtask
    task automatic doReset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        step(s);
    endtask
    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask
    always @(negedge CLK) begin : monitor
        resp_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {enables(), bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.halt_out, bus.stall_cnt, bus.flush_cnt};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got en=%b fl=%b halt=%b stall=%0d flush=%0d expected en=%b fl=%b halt=%b stall=%0d flush=%0d",
                         $time, a.en, a.fl, a.halt, a.stall, a.flush, e.en, e.fl, e.halt, e.stall, e.flush);
            end
        end
    end
    initial begin
        stim_t s;
        doReset();
        #1 chk("reset_enables", enables(), 31);
        chk("reset_halt", bus.halt_out, 0);
        chk("reset_stall_cnt", bus.stall_cnt, 0);
        // load-use inserts a single bubble
        s = idle();
        s.memRead = 1;
        s.exRt = 5;
        s.rs = 5;
        step(s);
        #1 chk("lu_pc_en", bus.pc_en, 0);
        chk("lu_idex_flush", bus.idex_flush, 1);
        step(idle());
        #1 chk("lu_next_enables", enables(), 31);
        step(idle());
        #1 chk("lu_stall_cnt", bus.stall_cnt, 1);
        // load into r0 is not a hazard
        doReset();
        s = idle();
        s.memRead = 1;
        step(s);
        #1 chk("r0_pc_en", bus.pc_en, 1);
        step(idle());
        #1 chk("r0_stall_cnt", bus.stall_cnt, 0);
        // data memory wait
        doReset();
        s = idle();
        s.dmemreq = 1;
        s.dhit = 0;
        repeat (3) begin
            step(s);
            #1 chk("dwait_enables_low", enables(), 0);
        end
        s.dhit = 1;
        step(s);
        #1 chk("dwait_enables_hit", enables(), 31);
        step(idle());
        #1 chk("dwait_stall_cnt", bus.stall_cnt, 3);
        // branch wins over load-use
        doReset();
        s = idle();
        s.pcsrc = 1;
        s.memRead = 1;
        s.exRt = 7;
        s.rt = 7;
        step(s);
        #1 chk("br_flushes", {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 7);
        chk("br_pc_en", bus.pc_en, 1);
        step(idle());
        #1 chk("br_flush_cnt", bus.flush_cnt, 1);
        chk("br_stall_cnt", bus.stall_cnt, 0);
        // halt, then asynchronous reset mid-HALTED
        doReset();
        s = idle();
        s.halt = 1;
        step(s);
        step(idle());
        #1 chk("halt_out", bus.halt_out, 1);
        chk("halt_enables", enables(), 0);
        step(idle());
        #1 chk("halt_enables_held", enables(), 0);
        chk("halt_stall_pre", bus.stall_cnt, 1);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 chk("async_halt_out", bus.halt_out, 0);
        chk("async_stall_cnt", bus.stall_cnt, 0);
        chk("async_enables", enables(), 31);
        doReset();
        step(idle());
        #1 chk("post_reset_enables", enables(), 31);
        // counter saturation
        doReset();
        s = idle();
        s.ihit = 0;
        repeat (20) step(s);
        step(idle());
        #1 chk("stall_sat", bus.stall_cnt, SAT);
        doReset();
        s = idle();
        s.pcsrc = 1;
        repeat (20) step(s);
        step(idle());
        #1 chk("flush_sat", bus.flush_cnt, SAT);
        // randomized traffic through the reference model
        doReset();
        repeat (3000) begin
            s.rst = $urandom_range(0, 39) == 0;
            s.halt = $urandom_range(0, 29) == 0;
            s.dmemreq = $urandom_range(0, 3) == 0;
            s.dhit = 1'($urandom_range(0, 1));
            s.ihit = $urandom_range(0, 3) != 0;
            s.pcsrc = $urandom_range(0, 5) == 0;
            s.memRead = 1'($urandom_range(0, 1));
            s.rs = regbits_t'($urandom_range(0, 3));
            s.rt = regbits_t'($urandom_range(0, 3));
            s.exRt = regbits_t'($urandom_range(0, 3));
            step(s);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain %0d responses never checked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 SHALL have port CLK, input, 1: system clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have ports ifid_rs and ifid_rt, input, regbits_t each: source registers of the instruction in decode.
REQ-005 SHALL have ports idex_MemRead (input, 1) and idex_rt (input, regbits_t): describe a load in execute.
REQ-006 SHALL have port exmem_dmemreq, input, 1: memory-stage load or store is pending.
REQ-007 SHALL have port dhit, input, 1: data memory completes this cycle.
REQ-008 SHALL have port ihit, input, 1: instruction fetch completes this cycle.
REQ-009 SHALL have port exmem_pcsrc, input, 1: branch taken or jump resolved in the memory stage.
REQ-010 SHALL have port memwb_halt, input, 1: halt instruction in writeback.
REQ-011 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 each: stage register write enables.
REQ-012 SHALL have ports ifid_flush, idex_flush and exmem_flush, output, 1 each: load a bubble into the stage register.
REQ-013 SHALL have port halt_out, output, 1: processor halted.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: performance counters.

Function
REQ-015 SHALL implement the FSM states RUN, LU_STALL, DWAIT and HALTED, encoded as hazard_state_t.
REQ-016 SHALL evaluate events in RUN by priority: memwb_halt, then (exmem_dmemreq && !dhit), then exmem_pcsrc, then load-use, then !ihit.
- memwb_halt goes to HALTED.
- Pending data access goes to DWAIT.
- exmem_pcsrc stays in RUN and asserts ifid_flush, idex_flush and exmem_flush for that cycle.
REQ-017 SHALL define load-use as idex_MemRead && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt).
- In RUN: pc_en=0, ifid_en=0, idex_flush=1 in the same cycle; next state LU_STALL.
REQ-018 SHALL keep all enables 1 in LU_STALL and return to RUN after exactly one cycle, so each load-use inserts exactly one bubble.
REQ-019 SHALL, in DWAIT, drive all five enables 0 and all flushes 0.
- Stays in DWAIT while !dhit.
- On dhit, asserts all enables that cycle and returns to RUN.
REQ-020 SHALL, on !ihit in RUN with no higher event, drive pc_en=0 and ifid_flush=1; other stages advance.
REQ-021 SHALL make HALTED absorbing until RST: all enables 0, all flushes 0, halt_out=1.
REQ-022 SHALL let exmem_pcsrc in LU_STALL take precedence: flush is applied and the state returns to RUN.
REQ-023 SHALL increment stall_cnt on every cycle with pc_en=0 outside HALTED, and flush_cnt on every cycle with exmem_pcsrc flush.
- Both counters saturate at all-ones.
REQ-024 SHALL, in RUN with no event, drive all enables 1 and all flushes 0.
REQ-025 SHALL compute outputs combinationally from the state and inputs, with the state and counters registered.

Reset
REQ-026 SHALL, while RST is asserted, immediately force: state RUN, stall_cnt=0, flush_cnt=0, halt_out=0.
REQ-027 SHALL, while RST is asserted, hold all enables 1 and all flushes 0.
REQ-028 SHALL abandon DWAIT, LU_STALL or HALTED when RST is asserted mid-operation, with no residual stall after release.

Structure
REQ-029 SHALL place hazard_state_t in cpu_types_pkg alongside regbits_t.
REQ-030 SHALL declare its ports in a hazard_unit_if interface with modport hu.
REQ-031 SHALL instantiate one sub-module sat_counter (parameter W) twice, for stall_cnt and flush_cnt.

Verification
REQ-032 SHALL cover load-use: idex_MemRead=1, idex_rt=5, ifid_rs=5 -> pc_en=0 and idex_flush=1 for 1 cycle, then all enables 1, stall_cnt=1.
REQ-033 SHALL cover the register-0 exception: idex_MemRead=1, idex_rt=0, ifid_rt=0 -> no stall, stall_cnt stays 0.
REQ-034 SHALL cover a data wait: exmem_dmemreq=1, dhit=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, all 1 on the dhit cycle, stall_cnt=3.
REQ-035 SHALL cover a simultaneous branch and load-use: exmem_pcsrc=1 with a load-use match -> three flushes asserted, pc_en=1, flush_cnt=1.
REQ-036 SHALL cover halt then reset: memwb_halt=1 -> halt_out=1 and enables 0 thereafter; RST pulse mid-HALTED -> halt_out=0 and counters 0 asynchronously.
